// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   F3_*        : memory size codes (byte / half / word)
//   state_t     : sequencer states
//   mem_cmd_t   : registered command payload driven onto the memory port
//   is_misaligned: alignment rule for half/word accesses
package dmem_arb_pkg;

    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned F3_W       = 3;

    localparam logic [F3_W-1:0] F3_BYTE = 3'b000;
    localparam logic [F3_W-1:0] F3_HALF = 3'b001;
    localparam logic [F3_W-1:0] F3_WORD = 3'b010;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [CMD_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     wdata;
        logic [F3_W-1:0]       funct3;
        logic                  src;
    } mem_cmd_t;

    // Half needs addr[0] clear, word needs addr[1:0] clear; bytes always align.
    function automatic logic is_misaligned(input logic [F3_W-1:0] funct3,
                                           input logic [1:0]      addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_HALF: mis = addr_lo[0];
            F3_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin grant with a one-bit priority pointer.
//   clk, reset : clock and synchronous active-high reset
//   valid      : per-requester request valid
//   grant_c    : combinational one-hot grant, zero when idle or in reset
// The pointer moves to the losing index on every grant and holds otherwise.
module rr_arb2 #(
    parameter int unsigned RESET_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant_c
);

    logic prio_q;

    // Single requester wins outright; on contention the pointer decides.
    always_comb begin
        grant_c = 2'b00;
        if (!reset) begin
            case (valid)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = prio_q ? 2'b10 : 2'b01;
                default: grant_c = 2'b00;
            endcase
        end
    end

    // Loser index of the current grant becomes the next priority holder.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'(RESET_PRIO);
        end else if (grant_c != 2'b00) begin
            prio_q <= ~grant_c[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the shared data memory.
// Requester 0 = core load/store, requester 1 = debug/DMA.
//   clk, reset     : clock, synchronous active-high reset
//   req_*          : per-requester valid/ready request channel (2 lanes, packed)
//   rsp_valid_o    : one-cycle response pulse to the originating requester
//   rsp_rdata_o    : raw load word (0 for stores), rsp_err_o : misalignment flag
//   mem_*          : memory port, write on clk edge, combinational read on mem_rd
// Build option: DMEM_ARB_MISALIGN_CHK_EN enables misaligned-access suppression
// and the rsp_err_o flag; otherwise rsp_err_o is 0 and commands issue as-is.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RESET_PRIO = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [1:0]          req_we_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [63:0]         req_wdata_i,
    input  logic [5:0]          req_funct3_i,
    output logic [1:0]          rsp_valid_o,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_a,
    output logic [31:0]         mem_wd,
    output logic [2:0]          mem_funct3,
    input  logic [31:0]         mem_rd
);

    state_t      state_q, state_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic [1:0]  rsp_valid_d;
    logic [31:0] rsp_rdata_d;
    logic        rsp_err_d;

    logic [1:0]  grant_c;
    logic        accept_c;
    logic        src_c;
    logic        misalign_c;

    rr_arb2 #(
        .RESET_PRIO (RESET_PRIO)
    ) u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .valid   (req_valid_i),
        .grant_c (grant_c)
    );

    assign req_ready_o = grant_c;
    assign accept_c    = |grant_c;
    assign src_c       = grant_c[1];

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    assign misalign_c = is_misaligned(cmd_q.funct3, cmd_q.addr[1:0]);
`else
    assign misalign_c = 1'b0;
`endif

    // Command register holds its value in IDLE, so the memory bus keeps its
    // last values without extra holding registers.
    assign mem_a      = ADDR_W'(cmd_q.addr);
    assign mem_wd     = cmd_q.wdata;
    assign mem_funct3 = cmd_q.funct3;
    assign mem_we     = (state_q == ST_ACCESS) & cmd_q.we & ~reset & ~misalign_c;

    // Next state, command capture and response generation.
    always_comb begin
        state_d     = ST_IDLE;
        cmd_d       = cmd_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;

        if (accept_c) begin
            state_d      = ST_ACCESS;
            cmd_d.we     = src_c ? req_we_i[1] : req_we_i[0];
            cmd_d.addr   = CMD_ADDR_W'(src_c ? req_addr_i[2*ADDR_W-1:ADDR_W]
                                             : req_addr_i[ADDR_W-1:0]);
            cmd_d.wdata  = src_c ? req_wdata_i[63:32] : req_wdata_i[31:0];
            cmd_d.funct3 = src_c ? req_funct3_i[5:3] : req_funct3_i[2:0];
            cmd_d.src    = src_c;
        end

        if (state_q == ST_ACCESS) begin
            rsp_valid_d = cmd_q.src ? 2'b10 : 2'b01;
            rsp_err_d   = misalign_c;
            if (!cmd_q.we && !misalign_c) begin
                rsp_rdata_d = mem_rd;
            end
        end
    end

    // Reset drops any command in flight: no write (mem_we gated) and no response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            rsp_valid_o <= 2'b00;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_rdata_o <= rsp_rdata_d;
            rsp_err_o   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a transaction-level
// reference model (sequential memory semantics, round-robin priority rule).
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned RESET_PRIO = 0;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
    logic [2*ADDR_W-1:0] req_addr_i;
    logic [63:0]       req_wdata_i;
    logic [5:0]        req_funct3_i;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [31:0]       mem_wd;
    logic [2:0]        mem_funct3;
    logic [31:0]       mem_rd;

    dmem_arbiter #(.ADDR_W(ADDR_W), .RESET_PRIO(RESET_PRIO)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_funct3_i(req_funct3_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Driver state
    logic [1:0]  d_v, d_we;
    logic [31:0] d_addr [2];
    logic [31:0] d_wd   [2];
    logic [2:0]  d_f3   [2];
    assign req_valid_i  = d_v;
    assign req_we_i     = d_we;
    assign req_addr_i   = {d_addr[1], d_addr[0]};
    assign req_wdata_i  = {d_wd[1], d_wd[0]};
    assign req_funct3_i = {d_f3[1], d_f3[0]};

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] apply_store(input logic [31:0] old, input logic [2:0] f3,
                                                input logic [1:0] lo, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        if (f3 == F3_BYTE)      r[int'(lo)*8 +: 8]     = wd[7:0];
        else if (f3 == F3_HALF) r[int'(lo[1])*16 +: 16] = wd[15:0];
        else                    r = wd;
        return r;
    endfunction

    function automatic bit misal(input logic [2:0] f3, input logic [31:0] a);
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        return ((f3 == F3_HALF) && (a % 2 != 0)) || ((f3 == F3_WORD) && (a % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    // Memory attached to the DUT port
    logic [31:0] ram [64];
    assign mem_rd = ram[mem_a[7:2]];
    always @(posedge clk)
        if (mem_we) ram[mem_a[7:2]] <= apply_store(ram[mem_a[7:2]], mem_funct3, mem_a[1:0], mem_wd);

    // Reference model state
    logic [31:0] ref_mem [64];
    bit          m_prio;
    bit          p_v, p_src, p_we;
    logic [31:0] p_addr, p_wd;
    logic [2:0]  p_f3;
    logic [1:0]  e_rv;
    logic [31:0] e_rd;
    bit          e_err;
    logic [1:0]  last_acc;

    task automatic set_req(input int r, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3);
        d_v[r] = 1'b1; d_we[r] = we; d_addr[r] = a; d_wd[r] = wd; d_f3[r] = f3;
    endtask

    // One clock: check combinational outputs, advance model, check responses.
    task automatic tick();
        logic [1:0] exp_ready;
        #1;
        exp_ready = 2'b00;
        if (!reset) begin
            if (d_v == 2'b01)      exp_ready = 2'b01;
            else if (d_v == 2'b10) exp_ready = 2'b10;
            else if (d_v == 2'b11) exp_ready = m_prio ? 2'b10 : 2'b01;
        end
        chk("req_ready", req_ready_o, exp_ready);
        chk("mem_we", mem_we, p_v && p_we && !reset && !misal(p_f3, p_addr));
        if (p_v) begin
            chk("mem_a", mem_a, p_addr);
            chk("mem_wd", mem_wd, p_wd);
            chk("mem_funct3", mem_funct3, p_f3);
        end
        last_acc = req_ready_o & d_v;
        @(posedge clk);
        e_rv = 2'b00; e_rd = 32'h0; e_err = 1'b0;
        if (p_v && !reset) begin
            e_rv = p_src ? 2'b10 : 2'b01;
            if (misal(p_f3, p_addr)) e_err = 1'b1;
            else if (p_we) ref_mem[p_addr[7:2]] = apply_store(ref_mem[p_addr[7:2]], p_f3, p_addr[1:0], p_wd);
            else e_rd = ref_mem[p_addr[7:2]];
        end
        p_v = 1'b0;
        if (exp_ready != 2'b00) begin
            p_src = exp_ready[1];
            p_v = 1'b1; p_we = d_we[p_src]; p_addr = d_addr[p_src];
            p_wd = d_wd[p_src]; p_f3 = d_f3[p_src];
            m_prio = ~p_src;
        end
        if (reset) m_prio = 1'(RESET_PRIO);
        #1;
        chk("rsp_valid", rsp_valid_o, e_rv);
        if (e_rv != 2'b00) begin
            chk("rsp_rdata", rsp_rdata_o, e_rd);
            chk("rsp_err", rsp_err_o, e_err);
        end
        d_v = d_v & ~last_acc;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && d_v != 2'b00; i++) tick();
        if (d_v != 2'b00) chk("drain_timeout", d_v, 2'b00);
        tick(); tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr(input logic [2:0] f3);
        logic [31:0] a;
        a = 32'($urandom_range(0, 255));
        if ($urandom % 4 != 0) begin
            if (f3 == F3_HALF) a = a & ~32'h1;
            if (f3 == F3_WORD) a = a & ~32'h3;
        end
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [2:0]  f3;
        bit          prio_before;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            ram[i] <= v; ref_mem[i] = v;
        end
        ram[1]  <= 32'h01020304; ref_mem[1]  = 32'h01020304;
        ram[8]  <= 32'h11223344; ref_mem[8]  = 32'h11223344;
        ram[12] <= 32'hCAFEF00D; ref_mem[12] = 32'hCAFEF00D;

        // Reset state, with requests pending
        reset = 1'b1;
        d_v = 2'b00; d_we = 2'b00;
        for (int r = 0; r < 2; r++) begin d_addr[r] = 0; d_wd[r] = 0; d_f3[r] = 0; end
        set_req(0, 1'b1, 32'h40, 32'h1234, F3_WORD);
        set_req(1, 1'b1, 32'h44, 32'h5678, F3_WORD);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", req_ready_o, 2'b00);
        chk("rst_rsp_valid", rsp_valid_o, 2'b00);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("rst_rsp_err", rsp_err_o, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        chk("rst_mem_funct3", mem_funct3, 3'b000);
        d_v = 2'b00; reset = 1'b0;
        m_prio = 1'(RESET_PRIO); p_v = 1'b0;

        // Requester 0: store then load same word
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, F3_WORD); tick();
        chk("t1_grant_st", last_acc, 2'b01);
        set_req(0, 1'b0, 32'h10, 32'h0, F3_WORD); tick();
        chk("t1_grant_ld", last_acc, 2'b01);
        tick();
        chk("t1_ld_valid", rsp_valid_o, 2'b01);
        chk("t1_ld_data", rsp_rdata_o, 32'hDEADBEEF);
        drain();

        // Contention from reset priority: grants alternate 0,1,0,1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (!d_v[0]) set_req(0, 1'b0, 32'(4 * i), 0, F3_WORD);
            if (!d_v[1]) set_req(1, 1'b0, 32'(64 + 4 * i), 0, F3_WORD);
            tick();
            chk("t2_grant", last_acc, (i % 2 == 1) ? 2'b10 : 2'b01);
        end
        drain();

        // Byte store by requester 1 then word load by requester 0
        set_req(1, 1'b1, 32'h21, 32'h000000AA, F3_BYTE); tick();
        set_req(0, 1'b0, 32'h20, 32'h0, F3_WORD); tick();
        tick();
        chk("t3_ld_valid", rsp_valid_o, 2'b01);
        chk("t3_ld_data", rsp_rdata_o, 32'h1122AA44);
        drain();

        // Reset during the ACCESS cycle of a store drops it
        set_req(0, 1'b1, 32'h30, 32'h55, F3_WORD); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t4_no_rsp", rsp_valid_o, 2'b00);
        tick();
        chk("t4_mem_kept", ram[12], 32'hCAFEF00D);
        set_req(0, 1'b0, 32'h0, 0, F3_WORD);
        set_req(1, 1'b0, 32'h4, 0, F3_WORD);
        tick();
        chk("t4_prio_reset", last_acc, (RESET_PRIO != 0) ? 2'b10 : 2'b01);
        drain();

        // Misaligned word store
        set_req(0, 1'b1, 32'h06, 32'hA5A5A5A5, F3_WORD); tick(); tick();
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        chk("t5_err", rsp_err_o, 1'b1);
        chk("t5_rdata", rsp_rdata_o, 32'h0);
        tick();
        chk("t5_mem", ram[1], 32'h01020304);
`else
        chk("t5_err", rsp_err_o, 1'b0);
        tick();
        chk("t5_mem", ram[1], 32'hA5A5A5A5);
`endif
        drain();

        // Idle stretch keeps priority
        prio_before = m_prio;
        for (int i = 0; i < 10; i++) tick();
        set_req(0, 1'b0, 32'h8, 0, F3_WORD);
        set_req(1, 1'b0, 32'hC, 0, F3_WORD);
        tick();
        chk("t6_prio_kept", last_acc, prio_before ? 2'b10 : 2'b01);
        drain();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!d_v[r] && ($urandom % 3 != 0)) begin
                    f3 = 3'($urandom_range(0, 2));
                    set_req(r, 1'($urandom % 2), rand_addr(f3), $urandom, f3);
                end
            end
            reset = ($urandom % 64 == 0);
            tick();
        end
        reset = 1'b0;
        drain();

        for (int i = 0; i < 64; i++) chk("final_mem", ram[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
